// File: rtl/shake_squeezer.sv
// shake_squeezer: captures the rate part of the permuted Keccak state and
// streams it as 64-bit words, requesting extra permutations for long output.
// Ports: clk, reset (async, active low), perm_out/perm_out_ready from the
// core, perm_in_ready to the core, start/out_len request, dout/dout_valid/
// dout_ready output stream, busy, done.
module shake_squeezer #(
  parameter int RATE = 576
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [1599:0] perm_out,
  input  logic          perm_out_ready,
  output logic          perm_in_ready,
  input  logic          start,
  input  logic [15:0]   out_len,
  output logic [63:0]   dout,
  output logic          dout_valid,
  input  logic          dout_ready,
  output logic          busy,
  output logic          done
);

  localparam int RW = RATE / 64;
  localparam logic [3:0] LAST = 4'(RW - 1);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_PERM,
    EMIT,
    REQ,
    DRAIN
  } state_e;

  state_e          state_q, state_d;
  logic [RATE-1:0] buf_q, buf_d;
  logic [3:0]      idx_q, idx_d;
  logic [15:0]     rem_q, rem_d;
  logic            armed_q, armed_d;
  logic            done_q, done_d;

  // Capacity bits of the state are never squeezed.
  logic unused_cap;
  assign unused_cap = ^perm_out[1599-RATE:0];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      buf_q   <= '0;
      idx_q   <= '0;
      rem_q   <= '0;
      armed_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      idx_q   <= idx_d;
      rem_q   <= rem_d;
      armed_q <= armed_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    idx_d   = idx_q;
    rem_d   = rem_q;
    armed_d = armed_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (out_len != 16'd0) begin
            rem_d   = out_len;
            armed_d = 1'b1;
            state_d = WAIT_PERM;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      WAIT_PERM: begin
        if (armed_q && perm_out_ready) begin
          buf_d   = perm_out[1599 -: RATE];
          idx_d   = 4'd0;
          state_d = EMIT;
        end
      end
      EMIT: begin
        if (dout_ready) begin
          // Word 0 sits at the top; shifting exposes the next word.
          buf_d = buf_q << 64;
          rem_d = rem_q - 16'd1;
          idx_d = idx_q + 4'd1;
          if (rem_q == 16'd1) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end else if (idx_q == LAST) begin
            state_d = REQ;
          end
        end
      end
      REQ: begin
        armed_d = 1'b0;
        state_d = DRAIN;
      end
      DRAIN: begin
        // out_ready must drop once so the stale block is not recaptured.
        if (!perm_out_ready) begin
          armed_d = 1'b1;
          state_d = WAIT_PERM;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign dout          = buf_q[RATE-1 -: 64];
  assign dout_valid    = (state_q == EMIT);
  assign perm_in_ready = (state_q == REQ);
  assign busy          = (state_q != IDLE);
  assign done          = done_q;

endmodule

// File: tb/tb_shake_squeezer.sv
// tb_shake_squeezer: table-driven and randomized checks of shake_squeezer
// against a behavioural permutation core and a word-queue model.
module tb_shake_squeezer;

  localparam int RW = 9;
  localparam logic [63:0] K00 = 64'hf1258f7940e1dde7;
  localparam logic [63:0] K01 = 64'h84d5ccf933c0478a;
  localparam logic [63:0] K10 = 64'h2d5c954df96ecb3c;
  localparam logic [63:0] K20 = 64'h0123456789abcdef;
  localparam logic [63:0] K28 = 64'hfedcba9876543210;

  logic          clk = 1'b0;
  logic          reset;
  logic [1599:0] perm_out;
  logic          perm_out_ready;
  logic          perm_in_ready;
  logic          start;
  logic [15:0]   out_len;
  logic [63:0]   dout;
  logic          dout_valid;
  logic          dout_ready;
  logic          busy;
  logic          done;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  shake_squeezer #(.RATE(576)) dut (
    .clk(clk),
    .reset(reset),
    .perm_out(perm_out),
    .perm_out_ready(perm_out_ready),
    .perm_in_ready(perm_in_ready),
    .start(start),
    .out_len(out_len),
    .dout(dout),
    .dout_valid(dout_valid),
    .dout_ready(dout_ready),
    .busy(busy),
    .done(done)
  );

  // Behavioural core: presents blocks[core_cur]; a request makes out_ready
  // drop and, 24 cycles later, the next block appears with out_ready high.
  logic [1599:0] blocks [0:63];
  int   core_cur = 0;
  int   core_cnt = 0;
  logic core_ready = 1'b1;
  logic kick = 1'b0;
  int   pulse_cnt = 0;

  assign perm_out = blocks[core_cur];
  assign perm_out_ready = core_ready;

  always @(posedge clk) begin
    if (perm_in_ready) pulse_cnt <= pulse_cnt + 1;
    if (kick || perm_in_ready) begin
      core_ready <= 1'b0;
      core_cnt   <= 24;
    end else if (core_cnt > 0) begin
      core_cnt <= core_cnt - 1;
      if (core_cnt == 1) begin
        core_ready <= 1'b1;
        core_cur   <= core_cur + 1;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] lane(input logic [1599:0] b, input int k);
    logic [1599:0] t;
    t = b >> (1536 - 64 * k);
    return t[63:0];
  endfunction

  task automatic squeeze(input int len, input bit bp, input bit inject,
                         output logic [63:0] w0, output logic [63:0] wl,
                         output int pulses);
    logic [63:0] exp_q[$];
    int   base;
    int   p0;
    bit   rdy0;
    int   got;
    logic pv, pr;
    logic [63:0] pd;
    base = core_cur;
    p0 = pulse_cnt;
    rdy0 = core_ready;
    w0 = '0;
    wl = '0;
    for (int i = 0; i < len; i++)
      exp_q.push_back(lane(blocks[base + i / RW], i % RW));
    @(negedge clk);
    start = 1'b1;
    out_len = 16'(len);
    dout_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", busy, 1);
    chk("valid_while_wait", dout_valid, 0);
    got = 0;
    pv = 1'b0;
    pr = 1'b0;
    pd = '0;
    for (int c = 0; c < 4000 && got < len; c++) begin
      @(negedge clk);
      if (c == 0 && rdy0) chk("first_valid", dout_valid, 1);
      if (pv && !pr) begin
        chk("stall_valid", dout_valid, 1);
        chk("stall_data", dout, pd);
      end
      start = inject && (c == 3);
      if (inject) out_len = 16'd2;
      dout_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      if (dout_valid && dout_ready) begin
        chk("word", dout, exp_q[got]);
        if (got == 0) w0 = dout;
        if (got == len - 1) wl = dout;
        got++;
      end
      pv = dout_valid;
      pr = dout_ready;
      pd = dout;
    end
    chk("word_count", 64'(got), 64'(len));
    @(negedge clk);
    start = 1'b0;
    dout_ready = 1'b0;
    chk("done_pulse", done, 1);
    chk("busy_end", busy, 0);
    @(negedge clk);
    chk("done_clear", done, 0);
    chk("no_valid_after", dout_valid, 0);
    pulses = pulse_cnt - p0;
  endtask

  typedef struct {
    int          len;
    bit          bp;
    bit          inject;
    int          exp_pulses;
    logic [63:0] exp_w0;
    logic [63:0] exp_wl;
  } vec_t;

  initial begin
    vec_t vecs [4];
    logic [1599:0] b;
    logic [63:0] w0, wl;
    int pulses;
    int acc;
    int base;
    int len;

    for (int n = 0; n < 64; n++) begin
      b = '0;
      for (int j = 0; j < 50; j++) b = {b[1567:0], 32'($urandom)};
      if (n == 0) begin
        b[1599 -: 64] = K00;
        b[1535 -: 64] = K01;
      end
      if (n == 1) b[1599 -: 64] = K10;
      if (n == 2) begin
        b[1599 -: 64] = K20;
        b[1599 - 64 * 8 -: 64] = K28;
      end
      blocks[n] = b;
    end

    vecs[0] = '{1, 1'b0, 1'b0, 0, K00, K00};
    vecs[1] = '{10, 1'b0, 1'b0, 1, K00, K20 ^ K20 ^ K10};
    vecs[2] = '{10, 1'b1, 1'b0, 1, K10, K20};
    vecs[3] = '{9, 1'b1, 1'b1, 0, K20, K28};

    reset = 1'b0;
    start = 1'b0;
    out_len = '0;
    dout_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_dout", dout, 0);
    chk("rst_valid", dout_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pir", perm_in_ready, 0);
    reset = 1'b1;
    @(negedge clk);

    for (int v = 0; v < 4; v++) begin
      squeeze(vecs[v].len, vecs[v].bp, vecs[v].inject, w0, wl, pulses);
      chk("vec_w0", w0, vecs[v].exp_w0);
      chk("vec_wlast", wl, vecs[v].exp_wl);
      chk("vec_pulses", 64'(pulses), 64'(vecs[v].exp_pulses));
    end

    // Zero-length request.
    @(negedge clk);
    start = 1'b1;
    out_len = 16'd0;
    @(negedge clk);
    start = 1'b0;
    chk("zero_done", done, 1);
    chk("zero_busy", busy, 0);
    chk("zero_valid", dout_valid, 0);
    @(negedge clk);
    chk("zero_done_clear", done, 0);
    chk("zero_busy2", busy, 0);

    // Reset in the middle of a block, while word 4 is on dout.
    base = core_cur;
    @(negedge clk);
    start = 1'b1;
    out_len = 16'd10;
    @(negedge clk);
    start = 1'b0;
    dout_ready = 1'b1;
    acc = 0;
    for (int c = 0; c < 100 && acc < 4; c++) begin
      @(negedge clk);
      if (dout_valid) acc++;
    end
    @(negedge clk);
    chk("pre_reset_word", dout, lane(blocks[base], 4));
    #1 reset = 1'b0;
    #1;
    chk("mid_rst_dout", dout, 0);
    chk("mid_rst_valid", dout_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_pir", perm_in_ready, 0);
    dout_ready = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("post_rst_busy", busy, 0);
    kick = 1'b1;
    @(negedge clk);
    kick = 1'b0;
    for (int c = 0; c < 100 && !core_ready; c++) @(negedge clk);
    chk("core_reperm", core_ready, 1);
    base = core_cur;
    squeeze(1, 1'b0, 1'b0, w0, wl, pulses);
    chk("restart_w0", w0, lane(blocks[base], 0));
    chk("restart_pulses", 64'(pulses), 0);

    // Randomized lengths and backpressure.
    for (int r = 0; r < 6; r++) begin
      len = $urandom_range(1, 27);
      squeeze(len, 1'($urandom_range(0, 1)), 1'b0, w0, wl, pulses);
      chk("rand_pulses", 64'(pulses), 64'((len - 1) / RW));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/shake_squeezer.md
# shake_squeezer

Squeeze-side output stage for the Keccak core. It sits directly downstream of `f_permutation`. Once absorption has finished, it captures the rate portion of the 1600-bit permuted state and serializes it as 64-bit words over a valid/ready handshake. When the caller wants more output than one rate block holds, it requests further permutations by feeding an all-zero block back into `f_permutation`. This gives extendable (SHAKE-style) output of arbitrary length for the Kyber sampling logic.

## Interface
- `RATE`, 576: rate in bits. It must be a multiple of 64. `RATE_WORDS` = `RATE`/64 (9 at the default).
- `clk` input 1: single clock; all state updates on the rising edge.
- `reset` input 1: asynchronous, active-low reset. While low, all registers are cleared and all outputs are driven to 0.
- `perm_out` input 1600: state from `f_permutation` `out`.
- `perm_out_ready` input 1: `f_permutation` `out_ready`.
- `perm_in_ready` output 1: drives `f_permutation` `in_ready`. The `in` bus of the core is tied to 0 by the integrator.
- `start` input 1: begin squeezing. Sampled only in `IDLE`.
- `out_len` input 16: number of 64-bit words to emit. Sampled together with `start`.
- `dout` output 64: output word.
- `dout_valid` output 1: `dout` holds a valid word.
- `dout_ready` input 1: the consumer accepts the word.
- `busy` output 1: high in every state except `IDLE`.
- `done` output 1: one-cycle pulse when the last word is accepted, or immediately after a `start` with `out_len` = 0.

## Operation
- Buffer: `RATE`-bit register `buf`, 4-bit word index `idx`, 16-bit counter `remaining`.
- Word k of a block is `perm_out[1599-64k -: 64]`, taken unswapped. It is emitted in the order k = 0..RATE_WORDS-1.
- FSM states: `IDLE`, `WAIT_PERM`, `EMIT`, `REQ`, `DRAIN`.
- `IDLE`: on `start`=1 with `out_len`≠0, load `remaining`=`out_len` and go to `WAIT_PERM` with `armed`=1. On `start`=1 with `out_len`=0, pulse `done` in the next cycle and stay in `IDLE`.
- `WAIT_PERM`: wait for `armed`=1 and `perm_out_ready`=1. Then capture `perm_out[1599:1600-RATE]` into `buf`, set `idx`=0, and go to `EMIT`.
- `EMIT`: `dout_valid`=1 and `dout`=`buf` word `idx`. On `dout_valid`&`dout_ready`, decrement `remaining` and increment `idx`.
  - If the new `remaining` is 0, go to `IDLE` and pulse `done` in the same cycle as the transition edge.
  - Otherwise, if the accepted word had `idx`=RATE_WORDS-1, go to `REQ`.
- `REQ`: `perm_in_ready`=1 for exactly one cycle, then go to `DRAIN` with `armed`=0.
- `DRAIN`/`armed`: after `REQ`, the block waits until it observes `perm_out_ready`=0 at least once, which sets `armed`=1, and then waits in `WAIT_PERM` for it to return to 1. This prevents recapturing the stale block.
- `dout` and `dout_valid` are held stable while `dout_valid`=1 and `dout_ready`=0.
- `start` is ignored while `busy`=1.
- `perm_in_ready` is never asserted outside `REQ`.
- Reset asserted mid-operation: return to `IDLE` immediately. `dout_valid`, `perm_in_ready`, `done` and `busy` go to 0, and `buf`, `idx` and `remaining` are cleared. An in-flight permutation in the core is not affected, and the next `start` captures whatever the core then presents.

## Timing
- Reset values of all outputs: 0.
- `start` at edge t with `perm_out_ready` already 1:
  - `WAIT_PERM` captures at edge t+1.
  - First `dout_valid` is at cycle t+1..t+2 (high after edge t+1).
- Within a block, throughput is one word per cycle when `dout_ready` is held high.
- Block boundary:
  - The last-word accept edge is followed by one `REQ` cycle.
  - Then comes the `f_permutation` latency (24 cycles from `in_ready` to `out_ready`).
  - Then there is one capture cycle before the next `dout_valid`.
- `done` coincides with the cycle after the final accept edge. `busy` falls in that same cycle.

## Test plan
- Integration with `f_permutation`: reset the core and feed one all-zero block, wait for `out_ready`, then `start` with `out_len`=1.
  - Required: `dout`=64'hf1258f7940e1dde7.
  - Required: `done` is pulsed one cycle after the accept edge.
  - Required: `perm_in_ready` never asserts.
- Same setup with `out_len`=10 and `dout_ready` held high.
  - Words 0 and 1 are 64'hf1258f7940e1dde7 and 64'h84d5ccf933c0478a.
  - Exactly one `perm_in_ready` pulse occurs, after word 8.
  - Word 9 is 64'h2d5c954df96ecb3c.
- Backpressure: toggle `dout_ready` pseudo-randomly during the `out_len`=10 run.
  - `dout` stays stable while stalled.
  - Same 10 words, with no duplicates or drops.
- `start` with `out_len`=0: `done` pulses the next cycle, `busy` stays 0, and `dout_valid` never asserts.
- Reset low for 2 cycles mid-`EMIT`, at word 4: all outputs go to 0 asynchronously. A restart with `out_len`=1 after re-permutation completes emits the core's current word 0.
- `start` pulsed while `busy`: no effect on `remaining` or the word sequence.
